magneton_ctrl: RTL and testbench

Magnetron enable controller for the microwave-oven control path. It synchronises the front-panel button and sensor inputs to the system clock and runs a two-state FSM that switches the magnetron on when start is pressed with the door closed. It switches the magnetron off on timer expiry, stop, clear or door opening. It sits between the panel/sensor inputs and the magnetron power driver, alongside the cook timer.

---
 rtl/magneton_pkg.sv | 19 +
 rtl/magneton_if.sv | 22 ++
 rtl/magneton_ctrl_sync_ff.sv | 24 ++
 rtl/magneton_ctrl.sv | 80 ++++++++
 tb/tb_magneton_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/magneton_pkg.sv
// Shared types and constants for the magnetron enable controller.
package magneton_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      COOK = 1'b1
   } mag_state_t;

   localparam int MAG_SYNC_STAGES_DEFAULT = 2;

   // Any one of these conditions forces the magnetron off.
   function automatic logic mag_off(input logic doorClosed,
                                    input logic timerDone,
                                    input logic stopReq,
                                    input logic clearReq);
      return !doorClosed | timerDone | stopReq | clearReq;
   endfunction

endpackage

// File: rtl/magneton_if.sv
// Panel/sensor inputs and magnetron outputs of the controller, as seen from the controller.
interface magneton_if;

   logic i_timer_done;
   logic i_door_closed;
   logic i_clearn;
   logic i_startn;
   logic i_stopn;
   logic o_mag_on;
   logic o_state;

   modport slave (
      input  i_timer_done, i_door_closed, i_clearn, i_startn, i_stopn,
      output o_mag_on, o_state
   );

   modport master (
      output i_timer_done, i_door_closed, i_clearn, i_startn, i_stopn,
      input  o_mag_on, o_state
   );

endinterface

// File: rtl/magneton_ctrl_sync_ff.sv
// N-stage single-bit synchroniser; reset loads every stage with RESET_VAL.
module sync_ff #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_stages;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stages <= {STAGES{RESET_VAL}};
      end else begin
         r_stages <= {r_stages[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_stages[STAGES-1];

endmodule

// File: rtl/magneton_ctrl.sv
// Magnetron enable controller: input synchronisers, start-edge detector and IDLE/COOK FSM.
module magneton_ctrl
   import magneton_pkg::*;
#(
   parameter int SYNC_STAGES = MAG_SYNC_STAGES_DEFAULT
) (
   input logic        clk,
   input logic        rst,
   magneton_if.slave  bus
);

   logic w_timer_done_s;
   logic w_door_closed_s;
   logic w_clearn_s;
   logic w_startn_s;
   logic w_stopn_s;
   logic w_flushed;
   logic w_start_ev;
   logic w_off;

   logic [SYNC_STAGES-1:0] r_flush;
   logic                   r_startn_hist;
   logic                   r_armed;
   logic                   r_mag_on;
   mag_state_t             r_state;
   mag_state_t             w_next;

   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_timer (
      .clk(clk), .rst(rst), .i_d(bus.i_timer_done), .o_q(w_timer_done_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_door (
      .clk(clk), .rst(rst), .i_d(bus.i_door_closed), .o_q(w_door_closed_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clear (
      .clk(clk), .rst(rst), .i_d(bus.i_clearn), .o_q(w_clearn_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_start (
      .clk(clk), .rst(rst), .i_d(bus.i_startn), .o_q(w_startn_s));
   sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_stop (
      .clk(clk), .rst(rst), .i_d(bus.i_stopn), .o_q(w_stopn_s));

   // Start edges only count once startn_s has shown a real released level after reset,
   // so a button still held across reset release cannot fake a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush       <= '0;
         r_startn_hist <= 1'b1;
         r_armed       <= 1'b0;
      end else begin
         r_flush       <= {r_flush[SYNC_STAGES-2:0], 1'b1};
         r_startn_hist <= w_startn_s;
         r_armed       <= r_armed | (w_flushed & w_startn_s);
      end
   end

   assign w_flushed  = &r_flush;
   assign w_start_ev = r_armed & r_startn_hist & ~w_startn_s;
   assign w_off      = mag_off(w_door_closed_s, w_timer_done_s, w_stopn_s, w_clearn_s);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start_ev && !w_off) w_next = COOK;
         COOK:    if (w_off) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // mag_on is loaded from the same next-state value so it always tracks the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_mag_on <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_mag_on <= (w_next == COOK);
      end
   end

   assign bus.o_mag_on = r_mag_on;
   assign bus.o_state  = logic'(r_state);

endmodule

// File: tb/tb_magneton_ctrl.sv
// Self-checking bench for magneton_ctrl: per-cycle vector table with a scoreboard queue plus latency sequences.
module tb_magneton_ctrl;

   typedef struct {
      logic rst;
      logic door;
      logic timer;
      logic clear;
      logic startn;
      logic stop;
      logic expMag;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   testsRun = 0;
   int   testsFailed = 0;
   vec_t vecs[$];
   logic expQ[$];

   magneton_if bus ();

   magneton_ctrl #(.SYNC_STAGES(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic addRow(input logic r, input logic d, input logic t, input logic c,
                         input logic s, input logic p, input logic e);
      vec_t v;
      v.rst = r; v.door = d; v.timer = t; v.clear = c;
      v.startn = s; v.stop = p; v.expMag = e;
      vecs.push_back(v);
   endtask

   // Normal operating row: door closed, no off request except as given.
   task automatic addRun(input int n, input logic s, input logic e);
      for (int k = 0; k < n; k++) addRow(1'b0, 1'b1, 1'b0, 1'b0, s, 1'b0, e);
   endtask

   task automatic checkOutput(input string name, input int idx, input logic actual, input logic expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s row %0d: got %0b, expected %0b", name, idx, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst               = v.rst;
      bus.i_door_closed = v.door;
      bus.i_timer_done  = v.timer;
      bus.i_clearn      = v.clear;
      bus.i_startn      = v.startn;
      bus.i_stopn       = v.stop;
   endtask

   initial begin
      logic expv;
      int   cnt;
      bus.i_door_closed = 1'b1;
      bus.i_timer_done  = 1'b0;
      bus.i_clearn      = 1'b0;
      bus.i_startn      = 1'b0;
      bus.i_stopn       = 1'b0;

      // reset held with start pressed and door closed
      for (int k = 0; k < 3; k++) addRow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addRun(2, 1'b0, 1'b0);
      addRun(2, 1'b1, 1'b0);
      addRun(2, 1'b0, 1'b0);
      addRun(2, 1'b0, 1'b1);
      // timer expiry during cook
      addRow(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      addRow(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      addRow(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      addRun(2, 1'b1, 1'b0);
      // start edge while timer held expired is discarded
      for (int k = 0; k < 3; k++) addRow(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      addRun(3, 1'b0, 1'b0);
      // interlock: press with door open, then close with button held
      for (int k = 0; k < 2; k++) addRow(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) addRow(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addRun(4, 1'b0, 1'b0);
      // cook, then open door for one cycle
      addRun(2, 1'b1, 1'b0);
      addRun(2, 1'b0, 1'b0);
      addRun(1, 1'b0, 1'b1);
      addRun(1, 1'b1, 1'b1);
      addRow(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      addRun(1, 1'b1, 1'b1);
      addRun(4, 1'b1, 1'b0);
      addRun(2, 1'b0, 1'b0);
      addRun(1, 1'b0, 1'b1);
      // stop pulse during cook
      addRow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      addRun(1, 1'b0, 1'b1);
      addRun(1, 1'b0, 1'b0);
      addRun(2, 1'b1, 1'b0);
      // stop on the same cycle as the press
      addRow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      addRun(4, 1'b0, 1'b0);
      // clear on the same cycle as the press
      addRun(2, 1'b1, 1'b0);
      addRow(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      addRun(3, 1'b0, 1'b0);
      // clear pulse during cook
      addRun(2, 1'b1, 1'b0);
      addRun(2, 1'b0, 1'b0);
      addRun(1, 1'b0, 1'b1);
      addRow(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      addRun(1, 1'b0, 1'b1);
      addRun(1, 1'b0, 1'b0);
      // reset mid-cook with the button held, then release and press again
      addRun(2, 1'b1, 1'b0);
      addRun(2, 1'b0, 1'b0);
      addRun(1, 1'b0, 1'b1);
      addRow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      addRun(4, 1'b0, 1'b0);
      addRun(2, 1'b1, 1'b0);
      addRun(2, 1'b0, 1'b0);
      addRun(1, 1'b0, 1'b1);

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         expQ.push_back(vecs[i].expMag);
         @(posedge clk);
         #1;
         expv = expQ.pop_front();
         checkOutput("mag_on", i, bus.o_mag_on, expv);
         checkOutput("state", i, bus.o_state, expv);
      end

      // stop latency from the sampling edge, counted in rising edges
      @(negedge clk);
      bus.i_stopn = 1'b1;
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
         bus.i_stopn = 1'b0;
      end while (bus.o_mag_on && cnt < 10);
      checkOutput("stop_latency", cnt, (cnt == 3), 1'b1);

      // button kept low must never restart
      expv = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         expv = expv | bus.o_mag_on;
      end
      checkOutput("held_start_no_restart", 0, expv, 1'b0);

      // start latency from the sampling edge of a fresh press
      @(negedge clk);
      bus.i_startn = 1'b1;
      repeat (3) @(negedge clk);
      bus.i_startn = 1'b0;
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!bus.o_mag_on && cnt < 10);
      checkOutput("start_latency", cnt, (cnt == 3), 1'b1);
      checkOutput("state_cook", cnt, bus.o_state, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
